// File: rtl/fpsu_ret_merge_if.sv
// Issue/retire bus for fpsu_ret_merge.
//   issue        per-port op issue strobe
//   issue_lanes  per-port lane mask of the issued op (port p at [p*LANES +: LANES])
//   lane_ret_en  per-lane completion strobe
//   lane_ret     per-lane status word (lane l of port p at [(p*LANES+l)*RETW +: RETW])
//   ret_en       per-port retire strobe
//   ret          per-port OR of the retiring op's lane status words
//   full         per-port tracker full
//   err          per-port sticky error (dropped issue or orphan lane return)
interface fpsu_ret_merge_if #(
  parameter int LANES = 2,
  parameter int PORTS = 3,
  parameter int RETW  = 14
);
  logic [PORTS-1:0]            issue;
  logic [PORTS*LANES-1:0]      issue_lanes;
  logic [PORTS*LANES-1:0]      lane_ret_en;
  logic [PORTS*LANES*RETW-1:0] lane_ret;
  logic [PORTS-1:0]            ret_en;
  logic [PORTS*RETW-1:0]       ret;
  logic [PORTS-1:0]            full;
  logic [PORTS-1:0]            err;

  modport master (
    output issue, issue_lanes, lane_ret_en, lane_ret,
    input  ret_en, ret, full, err
  );

  modport slave (
    input  issue, issue_lanes, lane_ret_en, lane_ret,
    output ret_en, ret, full, err
  );
endinterface

// File: rtl/fpsu_ret_merge.sv
// Per-port in-order retire merge for SIMD FP ops.
// Each port tracks up to DEPTH outstanding ops in a circular buffer. Every lane
// completion clears that lane's pending bit on the oldest op still waiting on it
// and ORs its status word into the op's accumulator. The head op retires once no
// lanes are pending; ret carries the merged status.
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  fpsu_ret_merge_if slave (issue / lane return inputs, retire outputs)
module fpsu_ret_merge #(
  parameter int LANES = 2,
  parameter int PORTS = 3,
  parameter int DEPTH = 4,
  parameter int RETW  = 14
) (
  input  logic            clk,
  input  logic            rst,
  fpsu_ret_merge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [DEPTH-1:0] valid, valid_n;
    logic [LANES-1:0] pend   [DEPTH];
    logic [LANES-1:0] pend_n [DEPTH];
    logic [RETW-1:0]  acc    [DEPTH];
    logic [RETW-1:0]  acc_n  [DEPTH];
    logic [AW-1:0]    head, tail, idx;
    logic [AW:0]      count;
    logic             err_q, orphan, hit, is_full, retire, push;
    logic [LANES-1:0] imask, ren;
    logic [LANES*RETW-1:0] rdata;

    assign imask   = bus.issue_lanes[p*LANES +: LANES];
    assign ren     = bus.lane_ret_en[p*LANES +: LANES];
    assign rdata   = bus.lane_ret[p*LANES*RETW +: LANES*RETW];
    assign is_full = (count == (AW+1)'(DEPTH));
    // Retire decision uses registered state only.
    assign retire  = valid[head] && (pend[head] == '0);
    assign push    = bus.issue[p] && !is_full;

    // Lane matching only sees entries valid before this edge, so a freshly
    // issued op (written at an invalid tail slot) can never be hit, and the
    // retiring head (no pending bits) is never hit either. Lanes are independent
    // bit updates, so several lanes landing on one entry merge cleanly.
    always_comb begin
      valid_n = valid;
      pend_n  = pend;
      acc_n   = acc;
      orphan  = 1'b0;
      hit     = 1'b0;
      idx     = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        hit = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
          idx = head + AW'(k);
          if (ren[l] && !hit && valid[idx] && pend[idx][l]) begin
            hit            = 1'b1;
            pend_n[idx][l] = 1'b0;
            acc_n[idx]     = acc_n[idx] | rdata[l*RETW +: RETW];
          end
        end
        if (ren[l] && !hit) orphan = 1'b1;
      end
      if (retire) valid_n[head] = 1'b0;
      if (push) begin
        valid_n[tail] = 1'b1;
        pend_n[tail]  = imask;
        acc_n[tail]   = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        err_q <= 1'b0;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          pend[d] <= '0;
          acc[d]  <= '0;
        end
      end else begin
        valid <= valid_n;
        pend  <= pend_n;
        acc   <= acc_n;
        if (retire) head <= head + 1'b1;
        if (push)   tail <= tail + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(retire);
        if ((bus.issue[p] && is_full) || orphan) err_q <= 1'b1;
      end
    end

    assign bus.ret_en[p]             = retire;
    assign bus.ret[p*RETW +: RETW]   = retire ? acc[head] : '0;
    assign bus.full[p]               = is_full;
    assign bus.err[p]                = err_q;
  end
endmodule

// File: tb/tb_fpsu_ret_merge.sv
module tb_fpsu_ret_merge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fpsu_ret_merge_if #(.LANES(2), .PORTS(3), .RETW(14)) b ();
  fpsu_ret_merge_if #(.LANES(4), .PORTS(1), .RETW(14)) b8 ();

  fpsu_ret_merge #(.LANES(2), .PORTS(3), .DEPTH(4), .RETW(14)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  fpsu_ret_merge #(.LANES(4), .PORTS(1), .DEPTH(8), .RETW(14)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout need finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    b.issue = '0; b.issue_lanes = '0; b.lane_ret_en = '0; b.lane_ret = '0;
    b8.issue = '0; b8.issue_lanes = '0; b8.lane_ret_en = '0; b8.lane_ret = '0;
  endtask

  task automatic do_issue(input int p, input logic [1:0] m);
    b.issue[p] = 1'b1;
    b.issue_lanes[p*2 +: 2] = m;
  endtask

  task automatic do_ret(input int p, input int l, input logic [13:0] v);
    b.lane_ret_en[p*2+l] = 1'b1;
    b.lane_ret[(p*2+l)*14 +: 14] = v;
  endtask

  task automatic apply_reset();
    clear_in();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL reset_ret_en got %b need 000", b.ret_en); end
    checks++; if (b.ret !== 42'd0) begin errors++; $display("FAIL reset_ret got %h need 0", b.ret); end
    checks++; if (b.full !== 3'b000) begin errors++; $display("FAIL reset_full got %b need 000", b.full); end
    checks++; if (b.err !== 3'b000) begin errors++; $display("FAIL reset_err got %b need 000", b.err); end
    checks++; if (b8.ret_en !== 1'b0 || b8.full !== 1'b0) begin errors++; $display("FAIL reset_dut8 got en=%b full=%b need 0 0", b8.ret_en, b8.full); end
  endtask

  // Two lanes return two cycles apart; merged status appears the cycle after the last.
  task automatic test_basic_merge();
    apply_reset();
    do_issue(0, 2'b11); tick(); clear_in();
    do_ret(0, 0, 14'h001); tick(); clear_in();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL basic_t1 ret_en got %b need 000", b.ret_en); end
    tick();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL basic_t2 ret_en got %b need 000", b.ret_en); end
    do_ret(0, 1, 14'h100); tick(); clear_in();
    checks++; if (b.ret_en !== 3'b001) begin errors++; $display("FAIL basic_t3 ret_en got %b need 001", b.ret_en); end
    checks++; if (b.ret[13:0] !== 14'h101) begin errors++; $display("FAIL basic_t3 ret got %h need 101", b.ret[13:0]); end
    tick();
    checks++; if (b.ret_en !== 3'b000 || b.ret !== 42'd0) begin errors++; $display("FAIL basic_t4 got en=%b ret=%h need 000 0", b.ret_en, b.ret); end
  endtask

  // Younger op completes first but waits for the head.
  task automatic test_in_order();
    apply_reset();
    do_issue(0, 2'b11); tick(); clear_in();
    do_issue(0, 2'b01); tick(); clear_in();
    do_ret(0, 0, 14'h001); tick(); clear_in();
    do_ret(0, 0, 14'h002); tick(); clear_in();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL order_wait ret_en got %b need 000", b.ret_en); end
    do_ret(0, 1, 14'h004); tick(); clear_in();
    checks++; if (b.ret_en[0] !== 1'b1 || b.ret[13:0] !== 14'h005) begin errors++; $display("FAIL order_a got en=%b ret=%h need 1 005", b.ret_en[0], b.ret[13:0]); end
    tick();
    checks++; if (b.ret_en[0] !== 1'b1 || b.ret[13:0] !== 14'h002) begin errors++; $display("FAIL order_b got en=%b ret=%h need 1 002", b.ret_en[0], b.ret[13:0]); end
    tick();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL order_done ret_en got %b need 000", b.ret_en); end
    checks++; if (b.err !== 3'b000) begin errors++; $display("FAIL order_err got %b need 000", b.err); end
  endtask

  task automatic test_overflow();
    logic [13:0] got [8];
    int n;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_issue(1, 2'b11); tick(); clear_in();
      if (i == 2) begin
        checks++; if (b.full[1] !== 1'b0) begin errors++; $display("FAIL ovf_full3 got %b need 0", b.full[1]); end
      end
      if (i == 3) begin
        checks++; if (b.full !== 3'b010) begin errors++; $display("FAIL ovf_full4 got %b need 010", b.full); end
        checks++; if (b.err !== 3'b000) begin errors++; $display("FAIL ovf_err4 got %b need 000", b.err); end
      end
    end
    checks++; if (b.err !== 3'b010) begin errors++; $display("FAIL ovf_err5 got %b need 010", b.err); end
    checks++; if (b.full !== 3'b010) begin errors++; $display("FAIL ovf_full5 got %b need 010", b.full); end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        do_ret(1, 0, 14'(k + 1));
        do_ret(1, 1, 14'((k + 1) << 4));
      end
      tick(); clear_in();
      if (b.ret_en[1] === 1'b1) begin
        if (n < 8) got[n] = b.ret[27:14];
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL ovf_retires got %0d need 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (n > k && got[k] !== 14'((k + 1) * 14'h11)) begin errors++; $display("FAIL ovf_ret%0d got %h need %h", k, got[k], 14'((k + 1) * 14'h11)); end
    end
    checks++; if (b.full !== 3'b000 || b.err !== 3'b010) begin errors++; $display("FAIL ovf_end got full=%b err=%b need 000 010", b.full, b.err); end
  endtask

  task automatic test_orphan();
    apply_reset();
    do_ret(2, 1, 14'h3ff); tick(); clear_in();
    checks++; if (b.err !== 3'b100) begin errors++; $display("FAIL orphan_err got %b need 100", b.err); end
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL orphan_ret_en got %b need 000", b.ret_en); end
    tick();
    checks++; if (b.err !== 3'b100 || b.ret_en !== 3'b000) begin errors++; $display("FAIL orphan_sticky got err=%b en=%b need 100 000", b.err, b.ret_en); end
  endtask

  // Return in the issue cycle must not hit the new op; full drops an issue even while head retires.
  task automatic test_same_cycle();
    apply_reset();
    do_issue(0, 2'b01); do_ret(0, 0, 14'h001); tick(); clear_in();
    checks++; if (b.err !== 3'b001 || b.ret_en !== 3'b000) begin errors++; $display("FAIL same_issue got err=%b en=%b need 001 000", b.err, b.ret_en); end
    do_ret(0, 0, 14'h007); tick(); clear_in();
    checks++; if (b.ret_en[0] !== 1'b1 || b.ret[13:0] !== 14'h007) begin errors++; $display("FAIL same_ret got en=%b ret=%h need 1 007", b.ret_en[0], b.ret[13:0]); end
    apply_reset();
    for (int i = 0; i < 4; i++) begin do_issue(0, 2'b01); tick(); clear_in(); end
    do_ret(0, 0, 14'h010); tick(); clear_in();
    checks++; if (b.ret_en[0] !== 1'b1 || b.full[0] !== 1'b1) begin errors++; $display("FAIL fullret_pre got en=%b full=%b need 1 1", b.ret_en[0], b.full[0]); end
    do_issue(0, 2'b00); tick(); clear_in();
    checks++; if (b.err[0] !== 1'b1 || b.full[0] !== 1'b0) begin errors++; $display("FAIL fullret_drop got err=%b full=%b need 1 0", b.err[0], b.full[0]); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) begin do_issue(0, 2'b11); tick(); clear_in(); end
    checks++; if (b.full[0] !== 1'b1) begin errors++; $display("FAIL midrst_full got %b need 1", b.full[0]); end
    rst = 1'b0;
    do_issue(0, 2'b00); do_ret(0, 0, 14'h001);
    tick(); clear_in();
    rst = 1'b1;
    checks++; if (b.ret_en !== 3'b000 || b.full !== 3'b000 || b.err !== 3'b000) begin errors++; $display("FAIL midrst_clear got en=%b full=%b err=%b need 000 000 000", b.ret_en, b.full, b.err); end
    tick();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL midrst_noret got %b need 000", b.ret_en); end
    do_issue(0, 2'b00); tick(); clear_in();
    checks++; if (b.ret_en !== 3'b001 || b.ret !== 42'd0) begin errors++; $display("FAIL midrst_zero got en=%b ret=%h need 001 0", b.ret_en, b.ret); end
    tick();
    checks++; if (b.ret_en !== 3'b000) begin errors++; $display("FAIL midrst_pop got %b need 000", b.ret_en); end
  endtask

  // LANES=4, DEPTH=8 instance against a queue model with random in-order returns.
  task automatic test_sweep();
    logic [3:0]  qp [$];
    logic [13:0] qa [$];
    logic [3:0]  tp;
    logic [13:0] v;
    logic        exp_en;
    int          n0, ret_cnt, found;
    apply_reset();
    ret_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n0 = qp.size();
      exp_en = (n0 > 0) && (qp[0] == 4'b0000);
      checks++; if (b8.ret_en[0] !== exp_en) begin errors++; $display("FAIL sweep_en c%0d got %b need %b", cyc, b8.ret_en[0], exp_en); end
      if (exp_en) begin
        ret_cnt++;
        checks++; if (b8.ret !== qa[0]) begin errors++; $display("FAIL sweep_ret c%0d got %h need %h", cyc, b8.ret, qa[0]); end
      end else begin
        checks++; if (b8.ret !== 14'd0) begin errors++; $display("FAIL sweep_ret0 c%0d got %h need 0", cyc, b8.ret); end
      end
      checks++; if (b8.full[0] !== (n0 == 8)) begin errors++; $display("FAIL sweep_full c%0d got %b need %b", cyc, b8.full[0], (n0 == 8)); end
      clear_in();
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 9) < 6) begin
          found = -1;
          for (int i = 0; i < qp.size(); i++) begin
            tp = qp[i];
            if (found < 0 && tp[l]) found = i;
          end
          if (found >= 0) begin
            v = 14'($urandom_range(0, 16383));
            b8.lane_ret_en[l] = 1'b1;
            b8.lane_ret[l*14 +: 14] = v;
            tp = qp[found]; tp[l] = 1'b0; qp[found] = tp;
            qa[found] = qa[found] | v;
          end
        end
      end
      if (exp_en) begin
        void'(qp.pop_front());
        void'(qa.pop_front());
      end
      if ($urandom_range(0, 9) < 5) begin
        tp = 4'($urandom_range(0, 15));
        b8.issue = 1'b1;
        b8.issue_lanes = tp;
        if (n0 < 8) begin
          qp.push_back(tp);
          qa.push_back(14'd0);
        end
      end
      tick();
    end
    clear_in();
    checks++; if (ret_cnt < 17) begin errors++; $display("FAIL sweep_wrap got %0d retires need >=17", ret_cnt); end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_basic_merge();
    test_in_order();
    test_overflow();
    test_orphan();
    test_same_cycle();
    test_mid_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
